// File: rtl/cnt_pkg.sv
// Shared definitions for the second-tick timer family.
package cnt_pkg;

  // Per-channel state encoding; later timer blocks reuse these values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ch_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_sec_ch.sv
// One timer channel: counts 1 s edges up to a latched terminal count, either once
// (one-shot) or repeatedly (periodic), with a sticky done flag and a one-cycle tick.
module cnt_sec_ch
  import cnt_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             clr_i,
  output logic             done_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  ch_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim_q;
  logic             mode_q;
  logic             done_q;
  logic             tick_q;
  logic [CNT_W-1:0] term_cnt;

  // Last count value before the terminal event; only used in RUN where lim_q != 0.
  assign term_cnt = lim_q - CntOne;

  // Channel FSM with all outputs registered; en low overrides everything else.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else if (!en_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lim_q   <= limit_i;
          mode_q  <= mode_i;
          cnt_q   <= '0;
          tick_q  <= 1'b0;
          done_q  <= 1'b0;
          // A zero limit parks the channel inert until en drops.
          state_q <= (limit_i != '0) ? ST_RUN : ST_HALT;
        end
        ST_RUN: begin
          if (cnt_q == term_cnt) begin
            // Terminal event beats a simultaneous clr.
            cnt_q   <= '0;
            tick_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= (mode_q == MODE_PERIODIC) ? ST_RUN : ST_HALT;
          end else begin
            cnt_q  <= cnt_q + CntOne;
            tick_q <= 1'b0;
            if (clr_i) done_q <= 1'b0;
          end
        end
        ST_HALT: begin
          tick_q <= 1'b0;
          if (clr_i) done_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
          tick_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done_o = done_q;
  assign tick_o = tick_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/cnt_sec_timer.sv
// Multi-channel second-tick timer: NUM_CH independent channels on the 1 s clock,
// with limit and cnt_val packed CNT_W bits per channel, channel 0 in the LSBs.
module cnt_sec_timer
  import cnt_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk_out,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] limit,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*CNT_W-1:0] cnt_val
);

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    cnt_sec_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_out(clk_out),
      .rst_n  (rst_n),
      .en_i   (en[g]),
      .mode_i (mode[g]),
      .limit_i(limit[g*CNT_W +: CNT_W]),
      .clr_i  (clr[g]),
      .done_o (done[g]),
      .tick_o (tick[g]),
      .cnt_o  (cnt_val[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_cnt_sec_timer.sv
// Bench for cnt_sec_timer: directed scenarios plus a randomized run against an
// edge-counting reference model (edges since load, modulo/compare against limit).
module tb_cnt_sec_timer;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int LIM_MAX = (1 << CNT_W) - 1;

  logic                    clk_out;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*CNT_W-1:0] limit;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH*CNT_W-1:0] cnt_val;

  int n_checks;
  int n_fail;

  // Reference model: per channel, edges elapsed since the load edge.
  bit   m_loaded[NUM_CH];
  int   m_k[NUM_CH];
  int   m_lim[NUM_CH];
  bit   m_per[NUM_CH];
  int   m_cnt[NUM_CH];
  logic m_tick[NUM_CH];
  logic m_done[NUM_CH];

  cnt_sec_timer #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_out(clk_out),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .limit  (limit),
    .clr    (clr),
    .done   (done),
    .tick   (tick),
    .cnt_val(cnt_val)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  function automatic int get_cnt(input int c);
    return int'(cnt_val[c*CNT_W +: CNT_W]);
  endfunction

  task automatic set_lim(input int c, input int v);
    limit[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_loaded[c] = 0;
      m_k[c] = 0;
      m_cnt[c] = 0;
      m_tick[c] = 1'b0;
      m_done[c] = 1'b0;
    end
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic step();
    logic [NUM_CH-1:0]       s_en;
    logic [NUM_CH-1:0]       s_mode;
    logic [NUM_CH-1:0]       s_clr;
    logic [NUM_CH*CNT_W-1:0] s_lim;
    logic                    s_rst;
    s_en = en; s_mode = mode; s_clr = clr; s_lim = limit; s_rst = rst_n;
    @(posedge clk_out);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!s_rst) begin
        m_loaded[c] = 0; m_cnt[c] = 0; m_tick[c] = 1'b0; m_done[c] = 1'b0;
      end else if (!s_en[c]) begin
        m_loaded[c] = 0; m_cnt[c] = 0; m_tick[c] = 1'b0; m_done[c] = 1'b0;
      end else if (!m_loaded[c]) begin
        m_loaded[c] = 1;
        m_lim[c] = int'(s_lim[c*CNT_W +: CNT_W]);
        m_per[c] = s_mode[c];
        m_k[c] = 0; m_cnt[c] = 0; m_tick[c] = 1'b0; m_done[c] = 1'b0;
      end else begin
        m_k[c]++;
        if (m_lim[c] == 0) begin
          m_cnt[c] = 0; m_tick[c] = 1'b0;
        end else if (m_per[c]) begin
          m_tick[c] = (m_k[c] % m_lim[c] == 0);
          m_cnt[c] = m_k[c] % m_lim[c];
        end else begin
          m_tick[c] = (m_k[c] == m_lim[c]);
          m_cnt[c] = (m_k[c] < m_lim[c]) ? m_k[c] : 0;
        end
        m_done[c] = m_tick[c] ? 1'b1 : (s_clr[c] ? 1'b0 : m_done[c]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; mode = '0; limit = '0; clr = '0;
    model_clear();
    #3;
    n_checks++;
    if ({done, tick, cnt_val} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got done=%b tick=%b cnt=%h, want all 0", done, tick, cnt_val);
    end
    step(); step();
    #1 rst_n = 1'b1;
    set_lim(0, 5); mode[0] = 1'b0; en[0] = 1'b1;
    step();
    step(); step(); step();
    n_checks++;
    if (get_cnt(0) !== 3) begin
      n_fail++;
      $display("FAIL reset_precount: got cnt0=%0d, want 3", get_cnt(0));
    end
    // Assert reset away from any edge; outputs must clear without a clock.
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if ({done, tick, cnt_val} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got done=%b tick=%b cnt=%h, want all 0", done, tick, cnt_val);
    end
    en = '0;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_oneshot();
    en = '0; step();
    set_lim(0, 5); mode[0] = 1'b0; en[0] = 1'b1;
    step();
    n_checks++;
    if (get_cnt(0) !== 0 || tick[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_load: got cnt0=%0d tick0=%b, want 0 0", get_cnt(0), tick[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++;
      if (get_cnt(0) !== i || tick[0] !== 1'b0 || done[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_count: edge %0d got cnt0=%0d tick0=%b done0=%b, want %0d 0 0",
                 i, get_cnt(0), tick[0], done[0], i);
      end
    end
    step();
    n_checks++;
    if (get_cnt(0) !== 0 || tick[0] !== 1'b1 || done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_term: got cnt0=%0d tick0=%b done0=%b, want 0 1 1",
               get_cnt(0), tick[0], done[0]);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (get_cnt(0) !== 0 || tick[0] !== 1'b0 || done[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL oneshot_hold: got cnt0=%0d tick0=%b done0=%b, want 0 0 1",
                 get_cnt(0), tick[0], done[0]);
      end
    end
    en = '0; step();
  endtask

  task automatic test_periodic();
    en = '0; step();
    set_lim(1, 3); mode[1] = 1'b1;
    set_lim(0, 10); mode[0] = 1'b0;
    en = '1;
    step();
    for (int e = 1; e <= 12; e++) begin
      step();
      n_checks++;
      if (tick[1] !== (e % 3 == 0) || get_cnt(1) !== e % 3) begin
        n_fail++;
        $display("FAIL periodic_ch1: edge %0d got tick1=%b cnt1=%0d, want %b %0d",
                 e, tick[1], get_cnt(1), (e % 3 == 0), e % 3);
      end
      n_checks++;
      if (tick[0] !== (e == 10) || done[0] !== (e >= 10)) begin
        n_fail++;
        $display("FAIL periodic_ch0: edge %0d got tick0=%b done0=%b, want %b %b",
                 e, tick[0], done[0], (e == 10), (e >= 10));
      end
    end
    en = '0; step();
  endtask

  task automatic test_clr();
    en = '0; clr = '0; step();
    set_lim(1, 3); mode[1] = 1'b1; en[1] = 1'b1;
    step();
    step(); step(); step();
    // Edge 4 after load is non-terminal.
    clr[1] = 1'b1;
    step();
    n_checks++;
    if (done[1] !== 1'b0 || tick[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_nonterm: got done1=%b tick1=%b, want 0 0", done[1], tick[1]);
    end
    clr[1] = 1'b0;
    step();
    clr[1] = 1'b1;
    step();
    n_checks++;
    if (done[1] !== 1'b1 || tick[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_term: got done1=%b tick1=%b, want 1 1", done[1], tick[1]);
    end
    clr[1] = 1'b0;
    step();
    n_checks++;
    if (done[1] !== 1'b1 || tick[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after: got done1=%b tick1=%b, want 1 0", done[1], tick[1]);
    end
    en = '0; step();
  endtask

  task automatic test_en_limit();
    en = '0; step();
    set_lim(0, 5); mode[0] = 1'b0; en[0] = 1'b1;
    step(); step(); step();
    n_checks++;
    if (get_cnt(0) !== 2) begin
      n_fail++;
      $display("FAIL en_precount: got cnt0=%0d, want 2", get_cnt(0));
    end
    en[0] = 1'b0;
    step();
    n_checks++;
    if (get_cnt(0) !== 0 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop: got cnt0=%0d done0=%b, want 0 0", get_cnt(0), done[0]);
    end
    set_lim(0, 2); en[0] = 1'b1;
    step();
    set_lim(0, 7);
    step();
    n_checks++;
    if (get_cnt(0) !== 1 || tick[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_reload1: got cnt0=%0d tick0=%b, want 1 0", get_cnt(0), tick[0]);
    end
    step();
    n_checks++;
    if (tick[0] !== 1'b1 || done[0] !== 1'b1 || get_cnt(0) !== 0) begin
      n_fail++;
      $display("FAIL en_reload2: got tick0=%b done0=%b cnt0=%0d, want 1 1 0",
               tick[0], done[0], get_cnt(0));
    end
    en = '0; step();
  endtask

  task automatic test_edge_limits();
    int bad;
    en = '0; step();
    set_lim(0, 0); mode[0] = 1'b1; en[0] = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL limit_zero: got %0d edges with tick0/done0 set, want 0", bad);
    end
    en = '0; step();
    set_lim(0, LIM_MAX); mode[0] = 1'b0; en[0] = 1'b1;
    step();
    for (int e = 1; e <= LIM_MAX; e++) begin
      step();
      n_checks++;
      if (e < LIM_MAX) begin
        if (get_cnt(0) !== e || tick[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL limit_max_count: edge %0d got cnt0=%0d tick0=%b, want %0d 0",
                   e, get_cnt(0), tick[0], e);
        end
      end else if (get_cnt(0) !== 0 || tick[0] !== 1'b1 || done[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL limit_max_term: got cnt0=%0d tick0=%b done0=%b, want 0 1 1",
                 get_cnt(0), tick[0], done[0]);
      end
    end
    step();
    n_checks++;
    if (get_cnt(0) !== 0 || tick[0] !== 1'b0 || done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_max_after: got cnt0=%0d tick0=%b done0=%b, want 0 0 1",
               get_cnt(0), tick[0], done[0]);
    end
    en = '0; step();
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 11) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 7) == 0) set_lim(c, LIM_MAX);
        else set_lim(c, int'($urandom_range(0, 6)));
        mode[c] = 1'($urandom_range(0, 1));
        clr[c] = ($urandom_range(0, 5) == 0);
      end
      step();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++;
        if (get_cnt(c) !== m_cnt[c] || tick[c] !== m_tick[c] || done[c] !== m_done[c]) begin
          n_fail++;
          $display("FAIL random ch%0d it%0d: got cnt=%0d tick=%b done=%b, want %0d %b %b",
                   c, it, get_cnt(c), tick[c], done[c], m_cnt[c], m_tick[c], m_done[c]);
        end
      end
    end
    en = '0; clr = '0; step();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_clr();
    test_en_limit();
    test_edge_limits();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_sec_timer.md
Name: cnt_sec_timer

Overview:
- Multi-channel, parametrised successor to the fixed 5-second counter.
- Runs NUM_CH independent second-tick counters on the 1 s clock (clk_out).
- Each channel has a runtime-programmable terminal count, one-shot or periodic mode, a sticky done flag and a single-cycle tick pulse.
- Feeds the control FSMs that need timeouts of varying length, for example 5 s and 10 s waits.

Parameters:
- NUM_CH, 2: number of independent timer channels (1..8).
- CNT_W, 4: counter and limit width in bits; maximum terminal count is 2^CNT_W-1.

Ports:
- clk_out  in   1  1 s period clock; all logic is on its rising edge.
- rst_n  in   1  asynchronous, active-low reset.
- en  in   NUM_CH  per-channel run enable; low means the channel is held cleared.
- mode  in   NUM_CH  per-channel mode, sampled at load: 0 = one-shot, 1 = periodic.
- limit  in   NUM_CH*CNT_W  per-channel terminal count, channel i at bits [i*CNT_W +: CNT_W]; sampled at load.
- clr  in   NUM_CH  per-channel done-flag clear, synchronous.
- done  out  NUM_CH  sticky per-channel "terminal count reached" flag.
- tick  out  NUM_CH  one-cycle pulse for each terminal-count event.
- cnt_val  out  NUM_CH*CNT_W  current count per channel, same packing as limit.

Behaviour:
- Reset (rst_n low, async): every channel goes to IDLE with cnt=0, done=0, tick=0, lim_q=0, mode_q=0. All outputs are 0 while reset is held.
- Channel state machine: IDLE, RUN, HALT. Channels never interact.
- en low at any edge, from any state: next state IDLE, cnt<=0, done<=0, tick<=0. This overrides clr and the terminal event.
- IDLE with en high:
  - lim_q<=limit, mode_q<=mode, cnt<=0, tick<=0.
  - Next state is RUN if limit!=0.
  - If limit==0, next state is HALT with done=0. The channel is inert until en drops.
- RUN with en high and cnt!=lim_q-1: cnt<=cnt+1, tick<=0.
- RUN with en high and cnt==lim_q-1 (terminal event): cnt<=0, tick<=1, done<=1.
  - mode_q=0: next state HALT.
  - mode_q=1: stay in RUN.
- Tick timing: the first tick is registered on the lim_q-th edge after the load edge. Periodic channels then tick every lim_q edges.
- HALT: cnt holds its value, tick<=0, done holds. Only en low leaves HALT.
- Mid-run changes to limit or mode: ignored. They take effect only after en goes low and then high again.
- clr high with en high: done<=0 on that edge, unless a terminal event occurs on the same edge. The terminal event wins and done stays 1.
- tick is high for exactly one clk_out cycle per terminal event.
- done is a registered level. It rises on the same edge as tick.
- Width rules:
  - cnt never exceeds lim_q-1 while in RUN.
  - The compare is unsigned CNT_W bits.
  - limit = 2^CNT_W-1 is legal and must not wrap.
- All outputs are registered; there is no combinational path from input to output.
- Reset asserted mid-count: the channel returns immediately to IDLE and all registers go to 0. After release, a channel with en high re-loads on the first edge.

Decomposition:
- Shared package cnt_pkg holds:
  - the channel state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2);
  - MODE_ONESHOT=1'b0 and MODE_PERIODIC=1'b1.
  - The package is reused by later timer blocks.
- Sub-module cnt_sec_ch implements one channel: state, cnt, lim_q, mode_q, done, tick.
- The top level is a generate loop over NUM_CH that slices the packed limit and cnt_val buses.

Test Plan:
- Reset check: assert rst_n low mid-count with ch0 cnt=3 -> done, tick and cnt_val go to 0 immediately, without waiting for a clock edge.
- One-shot, limit=5, en0 raised:
  - the load edge is followed by cnt 1,2,3,4;
  - on the 5th edge after load: tick0=1 for one cycle, done0=1, cnt0=0;
  - done0 then stays 1 and cnt0 stays 0 for 10 further edges.
- Periodic, limit=3 on ch1, ch0 one-shot limit=10, both enabled together:
  - ch1 ticks on edges 3, 6, 9 after load;
  - ch0 ticks once, on edge 10;
  - the channels are independent.
- clr interactions:
  - clr1 pulsed on a non-terminal edge -> done1 drops to 0;
  - clr1 on the same edge as a terminal event -> done1 stays 1 and tick1=1.
- en deassertion and limit sampling:
  - en0 dropped at cnt=2 -> next edge cnt0=0, done0=0;
  - re-raise en0 with limit changed from 5 to 2 -> tick on the 2nd edge after load;
  - a limit change while running has no effect.
- Edge limits:
  - limit=0 -> done and tick never assert over 20 edges;
  - limit=15 with CNT_W=4 -> tick on edge 15, with no wrap glitch at cnt=14->0.
